// File: rtl/fpu_issue_ctrl_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fpu_issue_ctrl_if
// Bundles the three handshakes around the FPU issue controller:
//   issue_*  : decoded float op from the execute stage (valid/ready)
//   fpu_*    : issue pulse, held operator/operands and result strobe to/from FPU
//   wb_*     : writeback handshake toward the register files
// Modports:
//   master : the controller itself (drives issue_ready, fpu_* requests, wb_*)
//   slave  : the surrounding core/FPU/regfile side
// ---------------------------------------------------------------------------
interface fpu_issue_ctrl_if #(
    parameter int RD_W = 5
);
    logic            issue_valid;
    logic            issue_ready;
    logic [2:0]      issue_op;
    logic [2:0]      issue_subop;
    logic [RD_W-1:0] issue_rd;
    logic [31:0]     issue_a;
    logic [31:0]     issue_b;

    logic            fpu_in_valid;
    logic [2:0]      fpu_operator;
    logic [2:0]      fpu_subop;
    logic [31:0]     fpu_a;
    logic [31:0]     fpu_b;
    logic            fpu_result_valid;
    logic [31:0]     fpu_c;

    logic            wb_valid;
    logic            wb_ready;
    logic [RD_W-1:0] wb_rd;
    logic [31:0]     wb_data;
    logic            wb_to_int;

    modport master (
        input  issue_valid, issue_op, issue_subop, issue_rd, issue_a, issue_b,
        output issue_ready,
        output fpu_in_valid, fpu_operator, fpu_subop, fpu_a, fpu_b,
        input  fpu_result_valid, fpu_c,
        output wb_valid, wb_rd, wb_data, wb_to_int,
        input  wb_ready
    );

    modport slave (
        output issue_valid, issue_op, issue_subop, issue_rd, issue_a, issue_b,
        input  issue_ready,
        input  fpu_in_valid, fpu_operator, fpu_subop, fpu_a, fpu_b,
        output fpu_result_valid, fpu_c,
        input  wb_valid, wb_rd, wb_data, wb_to_int,
        output wb_ready
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fpu_issue_ctrl
// Issue/writeback controller between the execute stage and the FPU wrapper.
// Accepts one float op at a time, pulses fpu_in_valid for one cycle, holds
// operator/subop/operands until the result (or an abort), then offers the
// result on the writeback handshake. CMP results target the integer regfile.
// Ports:
//   CLK          clock, all logic on posedge
//   INITIALIZE   synchronous active-high reset, aborts any operation in flight
//   bus          fpu_issue_ctrl_if.master (issue / fpu / wb handshakes)
//   busy         controller not idle (core stall hint)
//   err_timeout  sticky: an op was aborted because the FPU never answered
//   err_illegal  sticky: op code 7 was accepted
// ---------------------------------------------------------------------------
module fpu_issue_ctrl #(
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic                CLK,
    input  logic                INITIALIZE,
    fpu_issue_ctrl_if.master    bus,
    output logic                busy,
    output logic                err_timeout,
    output logic                err_illegal
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0]       OP_CMP      = 3'd5;
    localparam logic [2:0]       OP_ILLEGAL  = 3'd7;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [2:0]        op_reg;
    logic [2:0]        subop_reg;
    logic [31:0]       a_reg;
    logic [31:0]       b_reg;
    logic [RD_W-1:0]   rd_reg;
    logic [31:0]       data_reg;
    logic              to_int_reg;
    logic              err_timeout_reg;
    logic              err_illegal_reg;

    logic              issue_ready;
    logic              accept_legal;
    logic              accept_illegal;
    logic              waiting;
    logic              take_result;
    logic              timeout_hit;

    // State register
    always_ff @(posedge CLK) begin
        if (INITIALIZE) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_next     = state_reg;
        issue_ready    = (state_reg == ST_IDLE) ||
                         ((state_reg == ST_DONE) && bus.wb_ready);
        accept_legal   = bus.issue_valid && issue_ready && (bus.issue_op != OP_ILLEGAL);
        accept_illegal = bus.issue_valid && issue_ready && (bus.issue_op == OP_ILLEGAL);
        waiting        = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
        take_result    = waiting && bus.fpu_result_valid;
        // A result arriving on the very edge the counter expires still wins.
        timeout_hit    = waiting && !bus.fpu_result_valid && (cnt_reg == TIMEOUT_CNT);

        case (state_reg)
            ST_IDLE: begin
                if (accept_legal) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (take_result) begin
                    state_next = ST_DONE;
                end else if (timeout_hit) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_DONE: begin
                // Writeback completing together with a new accept goes straight
                // to ISSUE so back-to-back ops lose no cycle.
                if (bus.wb_ready) begin
                    state_next = accept_legal ? ST_ISSUE : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand capture, wait counter, result capture and sticky errors
    always_ff @(posedge CLK) begin
        if (INITIALIZE) begin
            cnt_reg         <= '0;
            op_reg          <= '0;
            subop_reg       <= '0;
            a_reg           <= '0;
            b_reg           <= '0;
            rd_reg          <= '0;
            data_reg        <= '0;
            to_int_reg      <= 1'b0;
            err_timeout_reg <= 1'b0;
            err_illegal_reg <= 1'b0;
        end else begin
            if (accept_legal) begin
                op_reg    <= bus.issue_op;
                subop_reg <= bus.issue_subop;
                a_reg     <= bus.issue_a;
                b_reg     <= bus.issue_b;
                rd_reg    <= bus.issue_rd;
                cnt_reg   <= '0;
            end else if (waiting) begin
                cnt_reg   <= cnt_reg + CNT_W'(1);
            end

            // Results outside ISSUE/WAIT are stale and never reach wb_data.
            if (take_result) begin
                data_reg   <= bus.fpu_c;
                to_int_reg <= (op_reg == OP_CMP);
            end

            if (timeout_hit) begin
                err_timeout_reg <= 1'b1;
            end
            if (accept_illegal) begin
                err_illegal_reg <= 1'b1;
            end
        end
    end

    assign bus.issue_ready  = issue_ready;
    assign bus.fpu_in_valid = (state_reg == ST_ISSUE);
    assign bus.fpu_operator = op_reg;
    assign bus.fpu_subop    = subop_reg;
    assign bus.fpu_a        = a_reg;
    assign bus.fpu_b        = b_reg;
    assign bus.wb_valid     = (state_reg == ST_DONE);
    assign bus.wb_rd        = rd_reg;
    assign bus.wb_data      = data_reg;
    assign bus.wb_to_int    = to_int_reg;
    assign busy             = (state_reg != ST_IDLE);
    assign err_timeout      = err_timeout_reg;
    assign err_illegal      = err_illegal_reg;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_fpu_issue_ctrl
// Table of directed transactions, hand-written multi-cycle sequences
// (back-to-back writeback, late result after timeout, reset in WAIT) and
// random transactions checked against a transaction-level expectation model.
// ---------------------------------------------------------------------------
module tb_fpu_issue_ctrl;
    localparam int TMO = 8;

    logic CLK = 1'b0;
    logic INITIALIZE;
    logic busy, err_timeout, err_illegal;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    fpu_issue_ctrl_if #(.RD_W(5)) bus ();

    fpu_issue_ctrl #(.RD_W(5), .TIMEOUT(TMO)) dut (
        .CLK         (CLK),
        .INITIALIZE  (INITIALIZE),
        .bus         (bus.master),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_illegal (err_illegal)
    );

    typedef struct {
        int          pulses;
        int          end_cyc;
        bit          got_wb;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        to_int;
        bit          ok;
    } obs_t;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  subop;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        int          lat;
        int          wbdly;
        bit          e_wb;
        bit          e_toint;
        bit          e_tout;
        bit          e_ill;
        int          e_cyc;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.issue_valid      = 1'b0;
        bus.issue_op         = 3'd0;
        bus.issue_subop      = 3'd0;
        bus.issue_rd         = 5'd0;
        bus.issue_a          = 32'd0;
        bus.issue_b          = 32'd0;
        bus.fpu_result_valid = 1'b0;
        bus.fpu_c            = 32'd0;
        bus.wb_ready         = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        INITIALIZE = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        INITIALIZE = 1'b0;
    endtask

    // Drives one op from IDLE. The FPU model answers lat cycles after the
    // in_valid cycle (lat > TMO means it never answers in time); writeback is
    // stalled wbdly cycles while stale result strobes are thrown at the DUT.
    task automatic run_op(input logic [2:0] op, input logic [2:0] subop, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input int lat, input int wbdly, output obs_t o);
        int  issued_at;
        bit  done;
        o.pulses = 0; o.end_cyc = -1; o.got_wb = 0; o.data = '0; o.rd = '0;
        o.to_int = 1'b0; o.ok = 1;
        issued_at = -1;
        done = 0;
        bus.issue_valid = 1'b1; bus.issue_op = op; bus.issue_subop = subop;
        bus.issue_rd = rd; bus.issue_a = a; bus.issue_b = b;
        #1;
        if (bus.issue_ready !== 1'b1) o.ok = 0;
        @(posedge CLK); #1;
        bus.issue_valid = 1'b0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            if (bus.wb_valid === 1'b1) begin
                o.end_cyc = cyc;
                o.got_wb = 1; o.data = bus.wb_data; o.rd = bus.wb_rd; o.to_int = bus.wb_to_int;
                for (int w = 0; w < wbdly; w++) begin
                    bus.wb_ready = 1'b0;
                    bus.fpu_result_valid = 1'b1;
                    bus.fpu_c = ~o.data;
                    #1;
                    if (bus.issue_ready !== 1'b0) o.ok = 0;
                    @(posedge CLK); #1;
                    if (bus.wb_valid !== 1'b1 || bus.wb_data !== o.data ||
                        bus.wb_rd !== o.rd || bus.wb_to_int !== o.to_int) o.ok = 0;
                end
                bus.fpu_result_valid = 1'b0;
                bus.wb_ready = 1'b1;
                @(posedge CLK); #1;
                bus.wb_ready = 1'b0;
                if (bus.wb_valid !== 1'b0 || busy !== 1'b0) o.ok = 0;
                done = 1;
                break;
            end
            if (busy !== 1'b1) begin
                o.end_cyc = cyc;
                done = 1;
                break;
            end
            if (bus.fpu_in_valid === 1'b1) begin
                o.pulses++;
                if (issued_at < 0) issued_at = cyc;
            end
            if (bus.fpu_operator !== op || bus.fpu_subop !== subop ||
                bus.fpu_a !== a || bus.fpu_b !== b) o.ok = 0;
            bus.fpu_result_valid = (issued_at >= 0) && (cyc - issued_at == lat);
            bus.fpu_c = bus.fpu_result_valid ? c : $urandom;
            @(posedge CLK); #1;
            bus.fpu_result_valid = 1'b0;
        end
        if (!done) o.ok = 0;
        if (op != 3'd7 && issued_at != 0) o.ok = 0;
        $display("txn op=%0d rd=%0d lat=%0d wbdly=%0d -> wb=%0d data=%h to_int=%0d cyc=%0d pulses=%0d ok=%0d",
                 op, rd, lat, wbdly, o.got_wb, o.data, o.to_int, o.end_cyc, o.pulses, o.ok);
    endtask

    // Transaction-level expectation: what the spec says happens to one op.
    task automatic model(input logic [2:0] op, input int lat,
                         output bit e_wb, output bit e_toint, output bit e_tout,
                         output bit e_ill, output int e_cyc, output int e_pulses);
        e_ill    = (op == 3'd7);
        e_wb     = !e_ill && (lat <= TMO);
        e_tout   = !e_ill && (lat > TMO);
        e_toint  = (op == 3'd5);
        e_pulses = e_ill ? 0 : 1;
        e_cyc    = e_ill ? 0 : (e_wb ? lat + 1 : TMO + 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=no_finish want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        bit   e_wb, e_toint, e_tout, e_ill;
        int   e_cyc, e_pulses;
        bit   st_tout, st_ill;

        vecs[0] = '{3'd1, 3'd0, 5'd3,  32'h3F800000, 32'h40000000, 32'h40400000, 5,  0, 1'b1, 1'b0, 1'b0, 1'b0, 6};
        vecs[1] = '{3'd5, 3'd2, 5'd7,  32'h40000000, 32'h3F800000, 32'h00000001, 2,  3, 1'b1, 1'b1, 1'b0, 1'b0, 3};
        vecs[2] = '{3'd4, 3'd0, 5'd12, 32'h41200000, 32'h00000000, 32'h7FC00000, 99, 0, 1'b0, 1'b0, 1'b1, 1'b0, 9};
        vecs[3] = '{3'd7, 3'd1, 5'd4,  32'h11111111, 32'h22222222, 32'h33333333, 1,  0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[4] = '{3'd3, 3'd0, 5'd31, 32'h40400000, 32'h40800000, 32'h41400000, 8,  1, 1'b1, 1'b0, 1'b0, 1'b0, 9};
        vecs[5] = '{3'd6, 3'd0, 5'd1,  32'h41800000, 32'hDEADBEEF, 32'h40800000, 9,  0, 1'b0, 1'b0, 1'b1, 1'b0, 9};
        vecs[6] = '{3'd0, 3'd0, 5'd2,  32'h3F800000, 32'hCAFEF00D, 32'hBF800000, 0,  2, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[7] = '{3'd2, 3'd5, 5'd9,  32'h40A00000, 32'h40000000, 32'h40400000, 1,  1, 1'b1, 1'b0, 1'b0, 1'b0, 2};

        // Reset state
        do_reset();
        chk("reset_ctrl", 64'({bus.fpu_in_valid, bus.fpu_operator, bus.fpu_subop, bus.wb_valid,
                               bus.wb_rd, bus.wb_to_int, busy, err_timeout, err_illegal}), 64'd0);
        chk("reset_fpu_ab", {bus.fpu_a, bus.fpu_b}, 64'd0);
        chk("reset_wb_data", 64'(bus.wb_data), 64'd0);
        chk("reset_issue_ready", 64'(bus.issue_ready), 64'd1);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            do_reset();
            run_op(vecs[i].op, vecs[i].subop, vecs[i].rd, vecs[i].a, vecs[i].b, vecs[i].c,
                   vecs[i].lat, vecs[i].wbdly, o);
            chk($sformatf("vec%0d_wb", i), 64'(o.got_wb), 64'(vecs[i].e_wb));
            if (vecs[i].e_wb) begin
                chk($sformatf("vec%0d_data", i), 64'(o.data), 64'(vecs[i].c));
                chk($sformatf("vec%0d_rd", i), 64'(o.rd), 64'(vecs[i].rd));
                chk($sformatf("vec%0d_to_int", i), 64'(o.to_int), 64'(vecs[i].e_toint));
            end
            chk($sformatf("vec%0d_err_timeout", i), 64'(err_timeout), 64'(vecs[i].e_tout));
            chk($sformatf("vec%0d_err_illegal", i), 64'(err_illegal), 64'(vecs[i].e_ill));
            chk($sformatf("vec%0d_cycles", i), 64'(o.end_cyc), 64'(vecs[i].e_cyc));
            chk($sformatf("vec%0d_pulses", i), 64'(o.pulses), 64'(vecs[i].e_ill ? 0 : 1));
            chk($sformatf("vec%0d_protocol", i), 64'(o.ok), 64'd1);
        end

        // Back-to-back: CMP stalled in DONE, then wb_ready with a new NEG
        do_reset();
        bus.issue_valid = 1'b1; bus.issue_op = 3'd5; bus.issue_subop = 3'd2;
        bus.issue_rd = 5'd9; bus.issue_a = 32'h3F800000; bus.issue_b = 32'h40000000;
        @(posedge CLK); #1;
        bus.issue_valid = 1'b0;
        @(posedge CLK); #1;
        bus.fpu_result_valid = 1'b1; bus.fpu_c = 32'h1;
        @(posedge CLK); #1;
        bus.fpu_result_valid = 1'b0;
        chk("b2b_cmp_wb_valid", 64'(bus.wb_valid), 64'd1);
        chk("b2b_cmp_data", 64'(bus.wb_data), 64'd1);
        chk("b2b_cmp_to_int", 64'(bus.wb_to_int), 64'd1);
        for (int w = 0; w < 3; w++) begin
            bus.wb_ready = 1'b0;
            bus.issue_valid = 1'b1; bus.issue_op = 3'd0; bus.issue_rd = 5'd4;
            bus.issue_a = 32'h12345678; bus.issue_b = 32'h0;
            #1;
            chk("b2b_stall_issue_ready", 64'(bus.issue_ready), 64'd0);
            @(posedge CLK); #1;
            chk("b2b_stall_hold", 64'({bus.wb_valid, bus.wb_to_int, bus.wb_rd, bus.wb_data}),
                64'({1'b1, 1'b1, 5'd9, 32'h1}));
        end
        bus.wb_ready = 1'b1;
        #1;
        chk("b2b_release_issue_ready", 64'(bus.issue_ready), 64'd1);
        @(posedge CLK); #1;
        bus.issue_valid = 1'b0; bus.wb_ready = 1'b0;
        chk("b2b_neg_pulse_no_bubble", 64'({bus.fpu_in_valid, bus.wb_valid, busy}), 64'b101);
        chk("b2b_neg_operands", 64'({bus.fpu_operator, bus.fpu_a}), 64'({3'd0, 32'h12345678}));
        @(posedge CLK); #1;
        chk("b2b_neg_pulse_width", 64'(bus.fpu_in_valid), 64'd0);
        bus.fpu_result_valid = 1'b1; bus.fpu_c = 32'hBF800000;
        @(posedge CLK); #1;
        bus.fpu_result_valid = 1'b0;
        chk("b2b_neg_wb", 64'({bus.wb_valid, bus.wb_to_int, bus.wb_rd, bus.wb_data}),
            64'({1'b1, 1'b0, 5'd4, 32'hBF800000}));
        bus.wb_ready = 1'b1;
        @(posedge CLK); #1;
        bus.wb_ready = 1'b0;
        chk("b2b_idle", 64'({busy, bus.wb_valid}), 64'd0);
        $display("txn back-to-back CMP->NEG done");

        // Timeout, late result ignored, errors sticky but non-blocking
        do_reset();
        run_op(3'd4, 3'd0, 5'd6, 32'h40000000, 32'h0, 32'h0, 99, 0, o);
        chk("tmo_no_wb", 64'(o.got_wb), 64'd0);
        chk("tmo_err", 64'(err_timeout), 64'd1);
        bus.fpu_result_valid = 1'b1; bus.fpu_c = 32'hDEADBEEF;
        @(posedge CLK); #1;
        bus.fpu_result_valid = 1'b0;
        chk("tmo_late_ignored", 64'({bus.wb_valid, busy, bus.issue_ready}), 64'b001);
        chk("tmo_late_data", 64'(bus.wb_data), 64'd0);
        run_op(3'd1, 3'd0, 5'd3, 32'h3F800000, 32'h40000000, 32'h40400000, 3, 0, o);
        chk("tmo_next_op_wb", 64'({o.got_wb, o.data}), 64'({1'b1, 32'h40400000}));
        chk("tmo_sticky", 64'(err_timeout), 64'd1);

        // INITIALIZE in WAIT, result the following cycle
        bus.issue_valid = 1'b1; bus.issue_op = 3'd3; bus.issue_rd = 5'd8;
        bus.issue_a = 32'h40000000; bus.issue_b = 32'h40000000;
        @(posedge CLK); #1;
        bus.issue_valid = 1'b0;
        @(posedge CLK); #1;
        INITIALIZE = 1'b1;
        @(posedge CLK); #1;
        INITIALIZE = 1'b0;
        bus.fpu_result_valid = 1'b1; bus.fpu_c = 32'h40800000;
        @(posedge CLK); #1;
        bus.fpu_result_valid = 1'b0;
        chk("init_wait_abort", 64'({bus.wb_valid, busy, err_timeout, err_illegal}), 64'd0);
        chk("init_wait_cleared", 64'({bus.wb_data, bus.fpu_a}), 64'd0);
        @(posedge CLK); #1;
        chk("init_wait_stays_idle", 64'({bus.wb_valid, busy}), 64'd0);
        $display("txn reset-in-WAIT done");

        // Random transactions against the expectation model
        do_reset();
        st_tout = 0; st_ill = 0;
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  r_op, r_sub;
            logic [4:0]  r_rd;
            logic [31:0] r_a, r_b, r_c;
            int          r_lat, r_dly;
            r_op  = 3'($urandom_range(0, 7));
            r_sub = 3'($urandom_range(0, 7));
            r_rd  = 5'($urandom_range(0, 31));
            r_a   = $urandom; r_b = $urandom; r_c = $urandom;
            r_lat = $urandom_range(0, 11);
            r_dly = $urandom_range(0, 3);
            model(r_op, r_lat, e_wb, e_toint, e_tout, e_ill, e_cyc, e_pulses);
            st_tout |= e_tout;
            st_ill  |= e_ill;
            run_op(r_op, r_sub, r_rd, r_a, r_b, r_c, r_lat, r_dly, o);
            chk($sformatf("rnd%0d_wb", n), 64'(o.got_wb), 64'(e_wb));
            if (e_wb) begin
                chk($sformatf("rnd%0d_wbfields", n), 64'({o.to_int, o.rd, o.data}),
                    64'({e_toint, r_rd, r_c}));
            end
            chk($sformatf("rnd%0d_cycles", n), 64'(o.end_cyc), 64'(e_cyc));
            chk($sformatf("rnd%0d_pulses", n), 64'(o.pulses), 64'(e_pulses));
            chk($sformatf("rnd%0d_errs", n), 64'({err_timeout, err_illegal}), 64'({st_tout, st_ill}));
            chk($sformatf("rnd%0d_protocol", n), 64'(o.ok), 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
